// File: rtl/key_expander_if.sv
// Cipher-facing bundle of the AES-128 key expander:
// load strobe, key, round-key read port and status.
interface key_expander_if #(
  parameter int KEY_S  = 128,
  parameter int ADDR_W = 4
);
  logic              en;
  logic [0:KEY_S-1]  key_i;
  logic              r_e;
  logic [0:ADDR_W-1] round_no;
  logic [0:KEY_S-1]  key_o;
  logic              busy;
  logic              ready;
  logic              done;

  modport master (
    output en, key_i, r_e, round_no,
    input  key_o, busy, ready, done
  );

  modport slave (
    input  en, key_i, r_e, round_no,
    output key_o, busy, ready, done
  );
endinterface

// File: rtl/key_expander.sv
// AES-128 key schedule: one round key per cycle into
// an 11-entry RAM, served through a registered read port.
module key_expander #(
  parameter int KEY_S  = 128,
  parameter int NR     = 10,
  parameter int ADDR_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  key_expander_if.slave  bus
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t            st, st_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [0:KEY_S-1]  wk, wk_n;
  logic              busy_n, ready_n, done_n;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [0:KEY_S-1]  wd;
  logic [0:KEY_S-1]  nk;
  logic [0:31]       w0, w1, w2, w3;
  logic [0:31]       t, n0, n1, n2, n3;

  logic [0:KEY_S-1]  rk [0:NR];

  function automatic logic [0:31] sub_word(
    input logic [0:31] w
  );
    return {SBOX[w[0:7]],   SBOX[w[8:15]],
            SBOX[w[16:23]], SBOX[w[24:31]]};
  endfunction

  function automatic logic [7:0] rcon(
    input logic [ADDR_W-1:0] i
  );
    logic [7:0] r;
    r = 8'h00;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign w0 = wk[0:31];
  assign w1 = wk[32:63];
  assign w2 = wk[64:95];
  assign w3 = wk[96:127];
  assign t  = sub_word({w3[8:31], w3[0:7]})
            ^ {rcon(cnt), 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign nk = {n0, n1, n2, n3};

  // Next-state, schedule step and RAM write control
  always_comb begin
    st_n    = st;
    cnt_n   = cnt;
    wk_n    = wk;
    busy_n  = bus.busy;
    ready_n = bus.ready;
    done_n  = 1'b0;
    we      = 1'b0;
    wa      = cnt;
    wd      = nk;
    unique case (st)
      IDLE: begin
        if (bus.en) begin
          we      = 1'b1;
          wa      = '0;
          wd      = bus.key_i;
          wk_n    = bus.key_i;
          cnt_n   = ADDR_W'(1);
          busy_n  = 1'b1;
          ready_n = 1'b0;
          st_n    = EXPAND;
        end
      end
      EXPAND: begin
        we    = 1'b1;
        wa    = cnt;
        wd    = nk;
        wk_n  = nk;
        cnt_n = cnt + ADDR_W'(1);
        if (cnt == ADDR_W'(NR)) begin
          busy_n  = 1'b0;
          ready_n = 1'b1;
          done_n  = 1'b1;
          st_n    = IDLE;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  // FSM, counter, working key and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= IDLE;
      cnt       <= '0;
      wk        <= '0;
      bus.busy  <= 1'b0;
      bus.ready <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      st        <= st_n;
      cnt       <= cnt_n;
      wk        <= wk_n;
      bus.busy  <= busy_n;
      bus.ready <= ready_n;
      bus.done  <= done_n;
    end
  end

  // Round-key RAM write port, array not reset
  always_ff @(posedge clk) begin
    if (we) rk[wa] <= wd;
  end

  // Registered read port; old data on same-address write
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.key_o <= '0;
    end else if (bus.r_e) begin
      if (bus.round_no <= ADDR_W'(NR))
        bus.key_o <= rk[bus.round_no];
      else
        bus.key_o <= '0;
    end
  end

endmodule

// File: tb/tb_key_expander.sv
// Scoreboard bench for key_expander: FIPS-197 A.1
// schedule, range/hold, retrigger and mid-run reset.
module tb_key_expander;
  localparam int KEY_S  = 128;
  localparam int NR     = 10;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  key_expander_if #(.KEY_S(KEY_S), .ADDR_W(ADDR_W)) bus ();

  key_expander #(
    .KEY_S(KEY_S), .NR(NR), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [0:127] fk [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  logic [0:127] k2    = 128'h000102030405060708090a0b0c0d0e0f;
  logic [0:127] k2r10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  logic [0:127] kx    = 128'hffeeddccbbaa99887766554433221100;

  logic [0:127] rd_q [$];
  int           done_q [$];
  int           busy_q [$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int run   = 0;
  bit rd_pend = 1'b0;

  task automatic chk(input string nm,
                     input logic [0:127] act,
                     input logic [0:127] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic extra(input string nm);
    total++;
    bad++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask

  always @(posedge clk) begin
    cyc++;
    rd_pend = bus.r_e;
  end

  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) extra("read_extra");
      else chk("read", bus.key_o, rd_q.pop_front());
    end
    if (bus.done) begin
      if (done_q.size() == 0) begin
        extra("done_extra");
      end else begin
        chk("done_cycle", cyc, done_q.pop_front());
        chk("ready_at_done", bus.ready, 1);
        chk("busy_at_done", bus.busy, 0);
      end
    end
    if (bus.busy) begin
      run++;
    end else if (run > 0) begin
      if (busy_q.size() == 0) extra("busy_extra");
      else chk("busy_len", run, busy_q.pop_front());
      run = 0;
    end
  end

  task automatic start(input logic [0:127] k,
                       input bit exp_done);
    bus.en = 1'b1;
    bus.key_i = k;
    if (exp_done) begin
      done_q.push_back(cyc + 11);
      busy_q.push_back(10);
    end
    @(negedge clk);
    bus.en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a,
                    input logic [0:127] e);
    bus.r_e = 1'b1;
    bus.round_no = a;
    rd_q.push_back(e);
    @(negedge clk);
    bus.r_e = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0;
    bus.key_i = '0;
    bus.r_e = 1'b0;
    bus.round_no = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_key_o", bus.key_o, 0);
      chk("idle_busy", bus.busy, 0);
      chk("idle_ready", bus.ready, 0);
      chk("idle_done", bus.done, 0);
    end

    start(fk[0], 1'b1);
    chk("busy_on", bus.busy, 1);
    chk("ready_off", bus.ready, 0);
    repeat (10) @(negedge clk);
    chk("ready_set", bus.ready, 1);
    chk("busy_clr", bus.busy, 0);
    @(negedge clk);
    chk("done_pulse_clr", bus.done, 0);
    rd(4'd0, fk[0]);
    rd(4'd1, fk[1]);
    rd(4'd10, fk[10]);

    for (int i = 0; i <= NR; i++) rd(4'(i), fk[i]);

    rd(4'd11, '0);
    rd(4'd15, '0);
    bus.round_no = 4'd2;
    @(negedge clk);
    chk("hold_zero", bus.key_o, 0);
    rd(4'd4, fk[4]);
    bus.round_no = 4'd7;
    repeat (2) @(negedge clk);
    chk("hold_rk4", bus.key_o, fk[4]);

    start(fk[0], 1'b1);
    chk("ready_drop", bus.ready, 0);
    repeat (3) @(negedge clk);
    bus.en = 1'b1;
    bus.key_i = kx;
    @(negedge clk);
    bus.en = 1'b0;
    repeat (6) @(negedge clk);
    rd(4'd10, fk[10]);
    rd(4'd1, fk[1]);

    start(k2, 1'b1);
    rd(4'd1, fk[1]);
    repeat (9) @(negedge clk);
    rd(4'd10, k2r10);
    rd(4'd0, k2);

    start(fk[0], 1'b0);
    busy_q.push_back(5);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.ready, 0);
    chk("rst_done", bus.done, 0);
    reset = 1'b0;
    @(negedge clk);
    start(fk[0], 1'b1);
    repeat (10) @(negedge clk);
    rd(4'd5, fk[5]);
    rd(4'd10, fk[10]);

    repeat (2) @(negedge clk);
    chk("rd_q_left", rd_q.size(), 0);
    chk("done_q_left", done_q.size(), 0);
    chk("busy_q_left", busy_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/key_expander.md
Name: key_expander

Overview:
- Upstream neighbour of the AES cipher core.
- Takes a 128-bit cipher key, expands it into Nr+1 round keys and stores them in an internal round-key RAM.
- Serves one round key per cycle to the cipher through a registered read port, addressed by the cipher's round_no with read enable r_e.
- Expansion runs at one round key per cycle, so a new key is ready 10 cycles after load.

Parameters:
- KEY_S, 128, key and round-key width in bits (AES-128 only).
- NR, 10, number of cipher rounds; RAM depth is NR+1 entries.
- ADDR_W, 4, round-key address width; matches round_no width.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  load strobe; starts expansion of key_i.
- key_i  input  [0:KEY_S-1]  cipher key; bit 0 is the MSB of word 0.
- r_e  input  1  round-key read enable from the cipher.
- round_no  input  [0:ADDR_W-1]  round-key read address.
- key_o  output reg  [0:KEY_S-1]  registered round key.
- busy  output reg  1  expansion in progress.
- ready  output reg  1  RAM holds a complete, valid schedule.
- done  output reg  1  one-cycle pulse when expansion completes.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: key_o=0, busy=0, ready=0, done=0, FSM=IDLE, round counter=0. RAM contents are not cleared; ready=0 marks them invalid.
- FSM state IDLE:
  - done<=0.
  - If en=1: write rk[0]<=key_i, latch key_i into the working register, counter<=1, busy<=1, ready<=0, go to EXPAND.
- FSM state EXPAND, each cycle:
  - Let w0..w3 be the 32-bit words of the working register, w0 at bits 0:31.
  - t = SubWord(RotWord(w3)) ^ {rcon[counter],24'h0}.
  - n0=w0^t; n1=w1^n0; n2=w2^n1; n3=w3^n2.
  - Write rk[counter]<={n0,n1,n2,n3} and working register<={n0,n1,n2,n3}; counter<=counter+1.
  - When counter==NR: busy<=0, ready<=1, done<=1, go to IDLE.
- SubWord uses the shared AES S-box function.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- RotWord rotates left by one byte: {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
- Latency: en sampled at edge E. rk0 is written at E; rk[i] is written at edge E+i. done, ready and busy=0 are visible after edge E+10. busy is high for exactly 10 cycles.
- Read port (independent of the FSM, active in every state):
  - If r_e=1 at an edge: key_o<=rk[round_no] when round_no<=NR, else key_o<=0.
  - If r_e=0: key_o holds its value.
  - Read latency is one cycle.
- Read/write same cycle: if r_e and an internal write target the same address in the same cycle, key_o returns the old contents (read-before-write).
- Reads while busy=1 or ready=0 return stale data; the cipher must not be started until ready=1.
- en while busy=1 is ignored; the expansion in progress completes unchanged.
- en in IDLE while ready=1 starts a new expansion; ready drops the next cycle.
- Reset mid-expansion: FSM returns to IDLE and busy=0, ready=0, done=0 next cycle; partially written RAM is treated as invalid.
- RAM maps to distributed or block RAM: synchronous write, synchronous read, no reset on the array.

Test Plan:
- Reset, then idle 5 cycles -> key_o=0, busy=0, ready=0, done=0 throughout.
- en=1 for one cycle with key_i=2b7e151628aed2a6abf7158809cf4f3c -> busy high 10 cycles, then done pulses 1 cycle and ready=1. Reads give:
  - round_no=0 -> 2b7e1516...09cf4f3c
  - round_no=1 -> a0fafe1788542cb123a339392a6c7605
  - round_no=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6
- Full-schedule sweep: r_e=1 with round_no 0..10 on consecutive cycles -> key_o matches the FIPS-197 Appendix A.1 round keys, one cycle after each address.
- Out-of-range and hold: round_no=11 and 15 with r_e=1 -> key_o=0. Then r_e=0 with round_no changed -> key_o unchanged.
- Reload and re-trigger:
  - Second en at cycle 4 of busy -> ignored; done still occurs at E+10 with the first key's schedule.
  - Subsequent en with key 000102030405060708090a0b0c0d0e0f -> rk10=13111d7fe3944a17f307a78b4d2b30c5.
- Reset asserted at cycle 5 of expansion -> next cycle busy=0, ready=0, done=0. A fresh en afterwards completes normally.
